spi_responder: RTL and testbench
================================

Name: spi_responder

Overview:
- 3-wire SPI target (responder) for the DAQ register bus. It is the far end of the team's SPI initiator.
- Oversamples sclk/csb/sdio with the local clk and decodes frames of the form R/W bit, then address, then data.
- Write frames produce a single-cycle register write strobe. Read frames fetch a word from user logic and drive it back on sdio.
- Used for loopback verification of the initiator and to expose firmware registers to an external SPI master.

Parameters:
ADDR_BITS, 7, address field width (bits after the R/W bit)
DATA_BITS, 8, data field width
SYNC_STAGES, 2, synchronizer depth on spi_sclk, spi_csb, spi_sdio_in (min 2)

Ports:
clk  in  1  local clock; must be >= 16x the sclk frequency
reset  in  1  asynchronous, active-high
spi_sclk  in  1  SPI clock from initiator (gated, idles low)
spi_csb  in  1  chip select, active-low
spi_sdio_in  in  1  sdio pad input
spi_sdio_out  out  1  sdio drive value
spi_sdio_oe  out  1  sdio drive enable; top level builds the tristate
reg_wr_en  out  1  one-clk write strobe
reg_wr_addr  out  ADDR_BITS  write address, valid with reg_wr_en
reg_wr_data  out  DATA_BITS  write data, valid with reg_wr_en
reg_rd_en  out  1  one-clk read request
reg_rd_addr  out  ADDR_BITS  read address, valid with reg_rd_en
reg_rd_data  in  DATA_BITS  sampled exactly 1 clk after reg_rd_en
frame_active  out  1  high while the synchronized csb is low
frame_error  out  1  one-clk pulse when a frame is aborted

Behaviour:
- Reset values: all outputs 0, state IDLE, shifters cleared. Synchronizer flops reset to sclk=0, csb=1, sdio=0.
- Edge detection uses the synchronized signals.
  - Rise and fall of sclk are each a one-clk event.
  - A csb fall starts a frame; a csb rise ends it.
- Sampling and driving:
  - Incoming bits are sampled on the sclk FALLING edge. The initiator changes sdio coincident with sclk rise, so the fall is mid-bit.
  - Outgoing bits are updated on sclk falling edges. The initiator samples them on the next sclk rise.
- Bit order:
  - R/W bit first: 1 = read.
  - Address is sent LSB-first; write data is sent LSB-first.
  - Read data is driven MSB-first, so the initiator's shift-left capture yields the natural value.
- State machine:
  - IDLE: on csb fall go to CMD; bit counter = 0.
  - CMD: on the first sampled bit, latch R/W and go to ADDR.
  - ADDR: shift in ADDR_BITS bits. On the last bit:
    - Write: go to WDATA.
    - Read: pulse reg_rd_en with the address in the same clk, then go to RFETCH.
  - RFETCH: 1 clk later, load reg_rd_data into the output shifter, set spi_sdio_out = MSB and spi_sdio_oe = 1, then go to RDATA.
    - Worst-case latency from the actual sclk fall to oe=1 is <= SYNC_STAGES+3 clk. This is within the half-period guaranteed by the 16x ratio.
  - WDATA: shift in DATA_BITS bits. On the last bit, pulse reg_wr_en with addr/data, then go to DONE.
  - RDATA: on each sclk fall, advance to the next bit. The fall after the last bit has been presented clears oe; then go to DONE.
  - DONE: ignore all further sclk edges until csb rises. Trailing clocks never cause a second strobe or re-drive.
- csb rise in any state: go to IDLE, oe = 0 in the same clk.
  - Rise before reg_wr_en (CMD/ADDR/WDATA), or before read data is fully driven (RFETCH/RDATA): frame_error pulses once. No write strobe is issued; a read already requested is not cancelled.
  - Rise in DONE or IDLE: no error.
- A csb fall while already in a frame cannot occur without an intervening rise; the rise always wins.
- A csb rise and an sclk edge in the same clk: the csb rise wins.
- reg_wr_en and reg_rd_en are never asserted together and are never asserted more than once per frame.
- Asynchronous reset mid-frame: outputs return to reset values immediately (oe drops asynchronously). The next frame requires a fresh csb fall.
- Frame lengths the initiator must use:
  - write: write_bits = 1+ADDR_BITS+DATA_BITS, read_bits = 0
  - read: write_bits = 1+ADDR_BITS, read_bits = DATA_BITS

Test Plan:
- Write: initiator data_out=0x0000A52A (data 0xA5, addr 0x15, rw 0), write_bits=16, read_bits=0 -> exactly one reg_wr_en with reg_wr_addr=0x15, reg_wr_data=0xA5; frame_error stays 0.
- Read: data_out=0x2B (addr 0x15, rw 1), write_bits=8, read_bits=8, user returns reg_rd_data=0x3C -> one reg_rd_en with addr 0x15; initiator data_in=0x0000003C; oe=0 after csb rise.
- Abort: write frame with csb forced high after 10 sclk -> no reg_wr_en, one frame_error pulse, state IDLE, oe=0.
- Over-length: write frame with write_bits=20 -> single reg_wr_en (addr 0x15, data 0xA5), extra bits ignored, no error.
- Back-to-back: write 0x5A to addr 0x7F, then immediately read addr 0x7F from a register model -> data_in=0x5A.
- Reset during RDATA after 3 bits -> spi_sdio_oe=0 asynchronously, all strobes 0; the next read frame returns correct data.

Source files
------------

// File: rtl/spi_responder.sv
// 3-wire SPI target: oversamples sclk/csb/sdio, decodes R/W + address + data frames
// and turns them into register-bus write strobes or read requests with sdio read-back.
module spi_responder #(
    parameter int ADDR_BITS   = 7,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_sclk,
    input  logic                 spi_csb,
    input  logic                 spi_sdio_in,
    output logic                 spi_sdio_out,
    output logic                 spi_sdio_oe,
    output logic                 reg_wr_en,
    output logic [ADDR_BITS-1:0] reg_wr_addr,
    output logic [DATA_BITS-1:0] reg_wr_data,
    output logic                 reg_rd_en,
    output logic [ADDR_BITS-1:0] reg_rd_addr,
    input  logic [DATA_BITS-1:0] reg_rd_data,
    output logic                 frame_active,
    output logic                 frame_error
);
    localparam int MAX_BITS = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_RFETCH = 3'd3,
        ST_WDATA  = 3'd4,
        ST_RDATA  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r, csb_sync_r, sdio_sync_r;
    logic                   sclk_prev_r, csb_prev_r;
    logic                   sclk_s, csb_s, sdio_s;
    logic                   sclk_fall_s, csb_fall_s, csb_rise_s;
    state_t                 state_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic                   is_read_r;
    logic [ADDR_BITS-1:0]   addr_sh_r, addr_next_s;
    logic [DATA_BITS-2:0]   data_sh_r;
    logic [DATA_BITS-1:0]   data_next_s;
    logic [DATA_BITS-1:0]   out_sh_r;

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign csb_s       = csb_sync_r[SYNC_STAGES-1];
    assign sdio_s      = sdio_sync_r[SYNC_STAGES-1];
    assign sclk_fall_s = sclk_prev_r & ~sclk_s;
    assign csb_fall_s  = csb_prev_r & ~csb_s;
    assign csb_rise_s  = ~csb_prev_r & csb_s;
    // Both fields arrive LSB-first, so each new bit enters at the top and slides down.
    assign addr_next_s = {sdio_s, addr_sh_r[ADDR_BITS-1:1]};
    assign data_next_s = {sdio_s, data_sh_r};

    // Pad synchronizers and one-clk-delayed copies for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            csb_sync_r  <= {SYNC_STAGES{1'b1}};
            sdio_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_prev_r <= 1'b0;
            csb_prev_r  <= 1'b1;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
            csb_sync_r  <= {csb_sync_r[SYNC_STAGES-2:0], spi_csb};
            sdio_sync_r <= {sdio_sync_r[SYNC_STAGES-2:0], spi_sdio_in};
            sclk_prev_r <= sclk_s;
            csb_prev_r  <= csb_s;
        end
    end

    // Frame decoder FSM with all register-bus and sdio outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= {CNT_W{1'b0}};
            is_read_r    <= 1'b0;
            addr_sh_r    <= {ADDR_BITS{1'b0}};
            data_sh_r    <= {(DATA_BITS-1){1'b0}};
            out_sh_r     <= {DATA_BITS{1'b0}};
            spi_sdio_out <= 1'b0;
            spi_sdio_oe  <= 1'b0;
            reg_wr_en    <= 1'b0;
            reg_wr_addr  <= {ADDR_BITS{1'b0}};
            reg_wr_data  <= {DATA_BITS{1'b0}};
            reg_rd_en    <= 1'b0;
            reg_rd_addr  <= {ADDR_BITS{1'b0}};
            frame_active <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            reg_wr_en    <= 1'b0;
            reg_rd_en    <= 1'b0;
            frame_error  <= 1'b0;
            frame_active <= ~csb_s;
            if (csb_rise_s) begin
                state_r      <= ST_IDLE;
                spi_sdio_oe  <= 1'b0;
                spi_sdio_out <= 1'b0;
                frame_error  <= (state_r != ST_IDLE) && (state_r != ST_DONE);
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (csb_fall_s) begin
                            state_r   <= ST_CMD;
                            bit_cnt_r <= {CNT_W{1'b0}};
                        end
                    end
                    ST_CMD: begin
                        if (sclk_fall_s) begin
                            is_read_r <= sdio_s;
                            bit_cnt_r <= {CNT_W{1'b0}};
                            state_r   <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_fall_s) begin
                            addr_sh_r <= addr_next_s;
                            if (bit_cnt_r == ADDR_LAST) begin
                                bit_cnt_r <= {CNT_W{1'b0}};
                                if (is_read_r) begin
                                    reg_rd_en   <= 1'b1;
                                    reg_rd_addr <= addr_next_s;
                                    state_r     <= ST_RFETCH;
                                end else begin
                                    state_r <= ST_WDATA;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + CNT_ONE;
                            end
                        end
                    end
                    ST_RFETCH: begin
                        out_sh_r     <= reg_rd_data;
                        spi_sdio_out <= reg_rd_data[DATA_BITS-1];
                        spi_sdio_oe  <= 1'b1;
                        state_r      <= ST_RDATA;
                    end
                    ST_WDATA: begin
                        if (sclk_fall_s) begin
                            data_sh_r <= data_next_s[DATA_BITS-1:1];
                            if (bit_cnt_r == DATA_LAST) begin
                                reg_wr_en   <= 1'b1;
                                reg_wr_addr <= addr_sh_r;
                                reg_wr_data <= data_next_s;
                                state_r     <= ST_DONE;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + CNT_ONE;
                            end
                        end
                    end
                    ST_RDATA: begin
                        // Rotating keeps every shifter bit live; bit N-2 is always the next to present.
                        if (sclk_fall_s) begin
                            if (bit_cnt_r == DATA_LAST) begin
                                spi_sdio_oe  <= 1'b0;
                                spi_sdio_out <= 1'b0;
                                state_r      <= ST_DONE;
                            end else begin
                                out_sh_r     <= {out_sh_r[DATA_BITS-2:0], out_sh_r[DATA_BITS-1]};
                                spi_sdio_out <= out_sh_r[DATA_BITS-2];
                                bit_cnt_r    <= bit_cnt_r + CNT_ONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_DONE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: an SPI initiator task, a register-file user model and a
// frame-level reference model; table-driven cases, random frames and a mid-frame reset.
module tb_spi_responder;
    localparam int AB   = 7;
    localparam int DB   = 8;
    localparam int HALF = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          spi_sclk = 1'b0;
    logic          spi_csb = 1'b1;
    logic          spi_sdio_in = 1'b0;
    logic          spi_sdio_out, spi_sdio_oe;
    logic          reg_wr_en, reg_rd_en, frame_active, frame_error;
    logic [AB-1:0] reg_wr_addr, reg_rd_addr;
    logic [DB-1:0] reg_wr_data, reg_rd_data;

    int tests = 0;
    int fails = 0;

    // user register file: written by DUT strobes, otherwise addr ^ 0x29
    logic [7:0]   user_regs [0:127];
    logic [127:0] user_valid = '0;
    int n_wr = 0, n_rd = 0, n_err = 0, n_both = 0;
    logic [6:0] got_wr_addr = '0, got_rd_addr = '0;
    logic [7:0] got_wr_data = '0;

    // reference model memory
    logic [7:0] model_mem [0:127];

    typedef struct {
        logic [31:0] word;
        int          wbits;
        int          rbits;
        int          stop;
        int          e_wr;
        logic [6:0]  e_addr;
        logic [7:0]  e_wdata;
        int          e_rd;
        int          chk_rdata;
        logic [7:0]  e_rdata;
        int          e_err;
    } vec_t;

    vec_t vecs [0:9];

    always #5 clk = ~clk;

    spi_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .spi_sclk(spi_sclk), .spi_csb(spi_csb), .spi_sdio_in(spi_sdio_in),
        .spi_sdio_out(spi_sdio_out), .spi_sdio_oe(spi_sdio_oe),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .frame_active(frame_active), .frame_error(frame_error)
    );

    assign reg_rd_data = user_valid[reg_rd_addr] ? user_regs[reg_rd_addr]
                                                 : ({1'b0, reg_rd_addr} ^ 8'h29);

    // strobe monitor and user register writes
    always @(negedge clk) begin
        if (!reset) begin
            if (reg_wr_en) begin
                n_wr        <= n_wr + 1;
                got_wr_addr <= reg_wr_addr;
                got_wr_data <= reg_wr_data;
                user_regs[reg_wr_addr]  <= reg_wr_data;
                user_valid[reg_wr_addr] <= 1'b1;
            end
            if (reg_rd_en) begin
                n_rd        <= n_rd + 1;
                got_rd_addr <= reg_rd_addr;
            end
            if (frame_error) n_err <= n_err + 1;
            if (reg_wr_en && reg_rd_en) n_both <= n_both + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Initiator: LSB-first bits of word driven at sclk rise, read bits captured at rise.
    task automatic frame(input logic [31:0] word, input int wbits, input int rbits,
                         input int stop, output logic [7:0] din, output int oe_bad);
        int total;
        total  = wbits + rbits;
        if (stop >= 0 && stop < total) total = stop;
        din    = 8'h00;
        oe_bad = 0;
        spi_csb = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < total; i++) begin
            spi_sclk = 1'b1;
            if (i < wbits) begin
                spi_sdio_in = word[i];
            end else begin
                spi_sdio_in = 1'b0;
                if (spi_sdio_oe !== 1'b1) oe_bad++;
                din = {din[6:0], spi_sdio_out};
            end
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        spi_csb     = 1'b1;
        spi_sdio_in = 1'b0;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Frame-level prediction from the bit stream and how many sclk cycles were given.
    task automatic model_frame(input logic [31:0] word, input int wbits, input int rbits,
                               input int stop, output int e_wr, output int e_rd,
                               output int e_err, output logic [6:0] e_addr,
                               output logic [7:0] e_wdata, output logic [7:0] e_rdata,
                               output int full_read);
        logic [31:0] stream;
        int k;
        k = wbits + rbits;
        if (stop >= 0 && stop < k) k = stop;
        stream    = word & ((32'd1 << wbits) - 32'd1);
        e_addr    = stream[7:1];
        e_wdata   = 8'h00;
        e_wr      = 0;
        e_rd      = 0;
        e_err     = (k < 1 + AB + DB) ? 1 : 0;
        e_rdata   = model_mem[e_addr];
        full_read = 0;
        if (k >= 1) begin
            if (stream[0] == 1'b0) begin
                if (k >= 1 + AB + DB) begin
                    e_wr    = 1;
                    e_wdata = stream[15:8];
                    model_mem[e_addr] = e_wdata;
                end
            end else if (k >= 1 + AB) begin
                e_rd = 1;
                if (k >= 1 + AB + DB && rbits >= DB) full_read = 1;
            end
        end
    endtask

    task automatic run(input string name, input vec_t v);
        int s_wr, s_rd, s_err, oe_bad;
        logic [7:0] din;
        s_wr = n_wr; s_rd = n_rd; s_err = n_err;
        frame(v.word, v.wbits, v.rbits, v.stop, din, oe_bad);
        check({name, "/wr_cnt"}, n_wr - s_wr, v.e_wr);
        check({name, "/rd_cnt"}, n_rd - s_rd, v.e_rd);
        check({name, "/err_cnt"}, n_err - s_err, v.e_err);
        if (v.e_wr == 1) begin
            check({name, "/wr_addr"}, got_wr_addr, v.e_addr);
            check({name, "/wr_data"}, got_wr_data, v.e_wdata);
        end
        if (v.e_rd == 1) check({name, "/rd_addr"}, got_rd_addr, v.e_addr);
        if (v.chk_rdata == 1) begin
            check({name, "/rd_data"}, din, v.e_rdata);
            check({name, "/oe_during_read"}, oe_bad, 0);
        end
        check({name, "/oe_after"}, spi_sdio_oe, 1'b0);
        check({name, "/active_after"}, frame_active, 1'b0);
    endtask

    initial begin
        vec_t v;
        int   fr;
        for (int i = 0; i < 128; i++) model_mem[i] = 8'(i) ^ 8'h29;

        //          word          wb  rb  stop wr addr   wdata  rd chk rdata  err
        vecs[0] = '{32'h0000002B,  8,  8, -1,  0, 7'h15, 8'h00, 1, 1, 8'h3C, 0};
        vecs[1] = '{32'h0000A52A, 16,  0, -1,  1, 7'h15, 8'hA5, 0, 0, 8'h00, 0};
        vecs[2] = '{32'h0000A52A, 20,  0, -1,  1, 7'h15, 8'hA5, 0, 0, 8'h00, 0};
        vecs[3] = '{32'h00007E2A, 16,  0, 10,  0, 7'h15, 8'h00, 0, 0, 8'h00, 1};
        vecs[4] = '{32'h00005AFE, 16,  0, -1,  1, 7'h7F, 8'h5A, 0, 0, 8'h00, 0};
        vecs[5] = '{32'h000000FF,  8,  8, -1,  0, 7'h7F, 8'h00, 1, 1, 8'h5A, 0};
        vecs[6] = '{32'h0000002B,  8,  8, -1,  0, 7'h15, 8'h00, 1, 1, 8'hA5, 0};
        vecs[7] = '{32'h0000002B,  8,  8, 11,  0, 7'h15, 8'h00, 1, 0, 8'h00, 1};
        vecs[8] = '{32'h0000002B,  8,  0, -1,  0, 7'h15, 8'h00, 1, 0, 8'h00, 1};
        vecs[9] = '{32'h0000FF00, 16,  0, -1,  1, 7'h00, 8'hFF, 0, 0, 8'h00, 0};

        // reset state
        repeat (4) @(negedge clk);
        check("rst/oe", spi_sdio_oe, 1'b0);
        check("rst/sdio_out", spi_sdio_out, 1'b0);
        check("rst/wr_en", reg_wr_en, 1'b0);
        check("rst/rd_en", reg_rd_en, 1'b0);
        check("rst/active", frame_active, 1'b0);
        check("rst/error", frame_error, 1'b0);
        check("rst/wr_addr", reg_wr_addr, 7'h00);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            model_frame(vecs[i].word, vecs[i].wbits, vecs[i].rbits, vecs[i].stop,
                        v.e_wr, v.e_rd, v.e_err, v.e_addr, v.e_wdata, v.e_rdata, fr);
            run($sformatf("vec%0d", i), vecs[i]);
        end

        // reset in the middle of the read data phase
        begin
            int s_rd;
            s_rd = n_rd;
            spi_csb = 1'b0;
            repeat (HALF) @(negedge clk);
            for (int i = 0; i < 12; i++) begin
                spi_sclk    = 1'b1;
                spi_sdio_in = (i < 8) ? 1'(32'h2B >> i) : 1'b0;
                repeat (HALF) @(negedge clk);
                if (i == 11) break;
                spi_sclk = 1'b0;
                repeat (HALF) @(negedge clk);
            end
            check("midrst/oe_before", spi_sdio_oe, 1'b1);
            check("midrst/rd_cnt", n_rd - s_rd, 1);
            @(negedge clk);
            reset    = 1'b1;
            spi_csb  = 1'b1;
            spi_sclk = 1'b0;
            #1;
            check("midrst/oe_async", spi_sdio_oe, 1'b0);
            check("midrst/sdio_out", spi_sdio_out, 1'b0);
            check("midrst/strobes", {reg_wr_en, reg_rd_en, frame_error}, 3'b000);
            check("midrst/active", frame_active, 1'b0);
            repeat (4) @(negedge clk);
            reset = 1'b0;
            repeat (2 * HALF) @(negedge clk);
            v.word = 32'h2B; v.wbits = 8; v.rbits = 8; v.stop = -1;
            model_frame(v.word, v.wbits, v.rbits, v.stop, v.e_wr, v.e_rd, v.e_err,
                        v.e_addr, v.e_wdata, v.e_rdata, v.chk_rdata);
            run("post_reset_read", v);
        end

        // random frames against the model
        for (int n = 0; n < 14; n++) begin
            logic [6:0] a;
            logic [7:0] d;
            a = 7'($urandom_range(0, 127));
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) begin
                v.word  = {16'h0, d, a, 1'b0};
                v.wbits = 16 + $urandom_range(0, 4);
                v.rbits = 0;
            end else begin
                v.word  = {24'h0, a, 1'b1};
                v.wbits = 8;
                v.rbits = 8;
            end
            v.stop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, v.wbits + v.rbits - 1) : -1;
            model_frame(v.word, v.wbits, v.rbits, v.stop, v.e_wr, v.e_rd, v.e_err,
                        v.e_addr, v.e_wdata, v.e_rdata, v.chk_rdata);
            run($sformatf("rand%0d", n), v);
        end

        check("never_both_strobes", n_both, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
